ship_anim_ctrl: RTL and testbench

Per-player animation and addressing controller for the ship sprite RAM. One instance per player. Each instance sequences the ship through idle, move-left, move, attack and dead poses from key inputs and hit events, and tracks hit points and invulnerability. It also produces the sprite RAM read address from the current draw coordinates, with the in-sprite flag and pose select delayed to line up with the RAM's registered output.

---
 rtl/ship_anim_ctrl_if.sv | 32 +++
 rtl/ship_anim_ctrl.sv | 121 ++++++++++++
 tb/tb_ship_anim_ctrl.sv | 194 +++++++++++++++++++
 3 files changed

// File: rtl/ship_anim_ctrl_if.sv
// Player control, draw-coordinate and status bundle for one ship_anim_ctrl instance.
// The master drives keys, hit, frame tick and coordinates; the slave returns address and status.
interface ship_anim_ctrl_if;
  logic        frame_tick;
  logic        key_left;
  logic        key_right;
  logic        key_attack;
  logic        hit;
  logic [9:0]  DrawX;
  logic [9:0]  DrawY;
  logic [9:0]  ship_x;
  logic [9:0]  ship_y;
  logic [18:0] read_address;
  logic [2:0]  pose_sel;
  logic        in_sprite;
  logic [2:0]  hp;
  logic        attack_active;
  logic        dead;
  logic        invuln;

  modport master (
    output frame_tick, key_left, key_right, key_attack, hit,
    output DrawX, DrawY, ship_x, ship_y,
    input  read_address, pose_sel, in_sprite, hp, attack_active, dead, invuln
  );

  modport slave (
    input  frame_tick, key_left, key_right, key_attack, hit,
    input  DrawX, DrawY, ship_x, ship_y,
    output read_address, pose_sel, in_sprite, hp, attack_active, dead, invuln
  );
endinterface

// File: rtl/ship_anim_ctrl.sv
// Per-player ship pose FSM with hit points / invulnerability, plus the sprite RAM
// address generator whose in-sprite and pose outputs line up with registered RAM data.
module ship_anim_ctrl #(
  parameter int SPR_W         = 80,
  parameter int SPR_H         = 80,
  parameter int HP_INIT       = 3,
  parameter int ATTACK_FRAMES = 20,
  parameter int INVULN_FRAMES = 60
) (
  input  logic             Clk,
  input  logic             Reset,
  ship_anim_ctrl_if.slave  bus
);

  localparam int AW = $clog2(ATTACK_FRAMES + 1);
  localparam int IW = $clog2(INVULN_FRAMES + 1);

  // Encoding doubles as the pose number.
  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    MOVE_L = 3'd1,
    MOVE_R = 3'd2,
    ATTACK = 3'd3,
    DEAD   = 3'd4
  } state_e;

  state_e         state_q, state_d, mv_sel;
  logic [2:0]     hp_q, hp_d;
  logic [AW-1:0]  atk_cnt_q, atk_cnt_d;
  logic [IW-1:0]  inv_cnt_q, inv_cnt_d;
  logic           key_atk_q, key_atk_d;
  logic           trig;

  logic [10:0]    dx, dy;
  logic           hit_box;
  logic [18:0]    read_address_q, read_address_d;
  logic           in_box_q, in_box_d;
  logic           in_sprite_q, in_sprite_d;
  logic [2:0]     pose_sel_q, pose_sel_d;

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q        <= IDLE;
      hp_q           <= 3'(HP_INIT);
      atk_cnt_q      <= '0;
      inv_cnt_q      <= '0;
      key_atk_q      <= 1'b0;
      read_address_q <= '0;
      in_box_q       <= 1'b0;
      in_sprite_q    <= 1'b0;
      pose_sel_q     <= 3'd0;
    end else begin
      state_q        <= state_d;
      hp_q           <= hp_d;
      atk_cnt_q      <= atk_cnt_d;
      inv_cnt_q      <= inv_cnt_d;
      key_atk_q      <= key_atk_d;
      read_address_q <= read_address_d;
      in_box_q       <= in_box_d;
      in_sprite_q    <= in_sprite_d;
      pose_sel_q     <= pose_sel_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    hp_d      = hp_q;
    atk_cnt_d = atk_cnt_q;
    inv_cnt_d = inv_cnt_q;
    key_atk_d = key_atk_q;
    trig      = bus.key_attack & ~key_atk_q;

    if (bus.key_left && !bus.key_right)      mv_sel = MOVE_L;
    else if (bus.key_right && !bus.key_left) mv_sel = MOVE_R;
    else                                     mv_sel = IDLE;

    if (bus.frame_tick) begin
      key_atk_d = bus.key_attack;
      if (inv_cnt_q != '0) inv_cnt_d = inv_cnt_q - 1'b1;
      if (state_q != DEAD) begin
        if (bus.hit && inv_cnt_q == '0) begin
          hp_d = hp_q - 3'd1;
          if (hp_q == 3'd1) state_d = DEAD;
          else              inv_cnt_d = IW'(INVULN_FRAMES);
        end
        // A surviving ship still gets its attack/movement update on the same tick.
        if (state_d != DEAD) begin
          if (state_q == ATTACK) begin
            if (atk_cnt_q == '0) state_d = mv_sel;
            else                 atk_cnt_d = atk_cnt_q - 1'b1;
          end else if (trig) begin
            state_d   = ATTACK;
            atk_cnt_d = AW'(ATTACK_FRAMES - 1);
          end else begin
            state_d = mv_sel;
          end
        end
      end
    end
  end

  // Zero-extended 11-bit differences: negative offsets set bit 10, so no wrap aliasing.
  always_comb begin
    dx             = {1'b0, bus.DrawX} - {1'b0, bus.ship_x};
    dy             = {1'b0, bus.DrawY} - {1'b0, bus.ship_y};
    hit_box        = !dx[10] && !dy[10] && (dx < 11'(SPR_W)) && (dy < 11'(SPR_H));
    read_address_d = hit_box ? (19'(dy[9:0]) * 19'(SPR_W) + 19'(dx[9:0])) : '0;
    in_box_d       = hit_box;
    in_sprite_d    = in_box_q;
    pose_sel_d     = 3'(state_q);
  end

  assign bus.read_address  = read_address_q;
  assign bus.in_sprite     = in_sprite_q;
  assign bus.pose_sel      = pose_sel_q;
  assign bus.hp            = hp_q;
  assign bus.attack_active = (state_q == ATTACK);
  assign bus.dead          = (state_q == DEAD);
  assign bus.invuln        = (inv_cnt_q != '0);

endmodule

// File: tb/tb_ship_anim_ctrl.sv
// Directed bench for ship_anim_ctrl: table of key/hit ticks with expected status,
// plus hand sequences for address pipeline, attack length, hits, death and reset.
module tb_ship_anim_ctrl;
  logic Clk;
  logic Reset;
  int   checks = 0;
  int   errors = 0;

  ship_anim_ctrl_if bus();

  ship_anim_ctrl dut (
    .Clk   (Clk),
    .Reset (Reset),
    .bus   (bus)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  typedef struct {
    logic l, r, a, h;
    int   pose, hp, dead, inv, atk;
  } vec_t;

  vec_t vecs[8];

  task automatic chk(input string nm, input int got, input int exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", nm, got, exp);
    end
  endtask

  task automatic chk_status(input string nm, input int pose, input int hp,
                            input int dead, input int inv, input int atk);
    chk({nm, ".pose"},   int'(bus.pose_sel),      pose);
    chk({nm, ".hp"},     int'(bus.hp),            hp);
    chk({nm, ".dead"},   int'(bus.dead),          dead);
    chk({nm, ".invuln"}, int'(bus.invuln),        inv);
    chk({nm, ".attack"}, int'(bus.attack_active), atk);
  endtask

  // One frame tick, then one extra cycle so pose_sel has caught up with the state.
  task automatic tick(input logic l, input logic r, input logic a, input logic h);
    bus.key_left   = l;
    bus.key_right  = r;
    bus.key_attack = a;
    bus.hit        = h;
    bus.frame_tick = 1'b1;
    @(posedge Clk); #1;
    bus.frame_tick = 1'b0;
    bus.hit        = 1'b0;
    @(posedge Clk); #1;
  endtask

  task automatic pix(input string nm, input int x, input int y, input int sx, input int sy,
                     input int exp_addr, input int exp_in);
    bus.DrawX  = 10'(x);
    bus.DrawY  = 10'(y);
    bus.ship_x = 10'(sx);
    bus.ship_y = 10'(sy);
    @(posedge Clk); #1;
    chk({nm, ".addr"}, int'(bus.read_address), exp_addr);
    @(posedge Clk); #1;
    chk({nm, ".in_sprite"}, int'(bus.in_sprite), exp_in);
  endtask

  task automatic pulse_reset();
    Reset = 1'b1;
    @(posedge Clk); #1;
    Reset = 1'b0;
  endtask

  initial begin
    vecs[0] = '{l:0, r:0, a:0, h:0, pose:0, hp:3, dead:0, inv:0, atk:0};
    vecs[1] = '{l:0, r:0, a:0, h:0, pose:0, hp:3, dead:0, inv:0, atk:0};
    vecs[2] = '{l:0, r:0, a:0, h:0, pose:0, hp:3, dead:0, inv:0, atk:0};
    vecs[3] = '{l:1, r:0, a:0, h:0, pose:1, hp:3, dead:0, inv:0, atk:0};
    vecs[4] = '{l:1, r:0, a:0, h:0, pose:1, hp:3, dead:0, inv:0, atk:0};
    vecs[5] = '{l:1, r:1, a:0, h:0, pose:0, hp:3, dead:0, inv:0, atk:0};
    vecs[6] = '{l:0, r:1, a:0, h:0, pose:2, hp:3, dead:0, inv:0, atk:0};
    vecs[7] = '{l:0, r:0, a:0, h:0, pose:0, hp:3, dead:0, inv:0, atk:0};

    Reset = 1'b1;
    bus.frame_tick = 1'b0; bus.key_left = 1'b0; bus.key_right = 1'b0;
    bus.key_attack = 1'b0; bus.hit = 1'b0;
    bus.DrawX = 10'd0; bus.DrawY = 10'd0; bus.ship_x = 10'd100; bus.ship_y = 10'd50;
    repeat (2) @(posedge Clk);
    #1;
    chk_status("reset", 0, 3, 0, 0, 0);
    chk("reset.addr", int'(bus.read_address), 0);
    chk("reset.in_sprite", int'(bus.in_sprite), 0);
    Reset = 1'b0;

    for (int i = 0; i < 8; i++) begin
      tick(vecs[i].l, vecs[i].r, vecs[i].a, vecs[i].h);
      chk_status($sformatf("vec%0d", i), vecs[i].pose, vecs[i].hp,
                 vecs[i].dead, vecs[i].inv, vecs[i].atk);
    end

    // Address path
    pix("corner",   179, 129, 100, 50, 6399, 1);
    pix("right_out",180, 129, 100, 50, 0,    0);
    pix("nowrap",   5,   129, 1000, 50, 0,   0);
    pix("origin",   100, 50,  100, 50, 0,    1);
    pix("below",    100, 130, 100, 50, 0,    0);
    pix("left_out", 99,  60,  100, 50, 0,    0);
    pix("mid",      150, 60,  100, 50, 850,  1);
    pix("edge_x",   1020, 60, 1000, 50, 820, 1);
    // Back-to-back pixels: in_sprite must trail the address by one cycle.
    bus.DrawX = 10'd179; bus.DrawY = 10'd129; bus.ship_x = 10'd100; bus.ship_y = 10'd50;
    @(posedge Clk); #1;
    bus.DrawX = 10'd0; bus.DrawY = 10'd0;
    chk("pipe.addr_a", int'(bus.read_address), 6399);
    @(posedge Clk); #1;
    chk("pipe.in_a", int'(bus.in_sprite), 1);
    chk("pipe.addr_b", int'(bus.read_address), 0);
    @(posedge Clk); #1;
    chk("pipe.in_b", int'(bus.in_sprite), 0);

    // Attack: 20 ticks, held key does not retrigger
    tick(0, 0, 1, 0);
    chk_status("atk0", 3, 3, 0, 0, 1);
    for (int i = 1; i < 20; i++) begin
      tick(0, 0, 1, 0);
      chk($sformatf("atk%0d.active", i), int'(bus.attack_active), 1);
    end
    tick(0, 0, 1, 0);
    chk_status("atk_end", 0, 3, 0, 0, 0);
    tick(0, 0, 1, 0);
    chk_status("atk_held", 0, 3, 0, 0, 0);

    // Second press during attack is ignored (no restart)
    tick(0, 0, 0, 0);
    tick(0, 0, 1, 0);
    chk("atk2_start.pose", int'(bus.pose_sel), 3);
    for (int i = 1; i < 20; i++) begin
      tick(0, 0, (i == 2), 0);
      chk($sformatf("atk2_%0d.active", i), int'(bus.attack_active), 1);
    end
    tick(1, 0, 0, 0);
    chk_status("atk2_end", 1, 3, 0, 0, 0);

    // Hits and invulnerability
    tick(0, 0, 0, 1);
    chk_status("hit1", 0, 2, 0, 1, 0);
    for (int i = 1; i <= 60; i++) begin
      tick(0, 0, 0, (i == 10));
      chk($sformatf("inv%0d.hp", i), int'(bus.hp), 2);
      chk($sformatf("inv%0d.invuln", i), int'(bus.invuln), (i < 60) ? 1 : 0);
    end
    tick(0, 0, 0, 1);
    chk_status("hit2", 0, 1, 0, 1, 0);
    for (int i = 62; i <= 121; i++) tick(0, 0, 0, 0);
    chk("hit2_clear.invuln", int'(bus.invuln), 0);
    tick(0, 0, 0, 1);
    chk_status("hit3", 4, 0, 1, 0, 0);
    tick(1, 0, 1, 1);
    chk_status("dead_keys", 4, 0, 1, 0, 0);
    tick(0, 1, 0, 0);
    chk_status("dead_keys2", 4, 0, 1, 0, 0);

    // Hit + attack edge with hp=2 -> survive and attack
    bus.DrawX = 10'd0; bus.DrawY = 10'd0; bus.ship_x = 10'd100; bus.ship_y = 10'd50;
    pulse_reset();
    chk_status("reset_dead", 0, 3, 0, 0, 0);
    tick(0, 0, 0, 1);
    repeat (60) tick(0, 0, 0, 0);
    chk("combo2_pre.hp", int'(bus.hp), 2);
    tick(0, 0, 1, 1);
    chk_status("combo2", 3, 1, 0, 1, 1);
    tick(0, 0, 1, 0);
    chk("combo2_hold.attack", int'(bus.attack_active), 1);

    // Reset mid-attack
    pulse_reset();
    chk_status("reset_atk", 0, 3, 0, 0, 0);
    chk("reset_atk.addr", int'(bus.read_address), 0);
    chk("reset_atk.in_sprite", int'(bus.in_sprite), 0);

    // Hit + attack edge with hp=1 -> dead, no attack
    tick(0, 0, 0, 1);
    repeat (60) tick(0, 0, 0, 0);
    tick(0, 0, 0, 1);
    repeat (60) tick(0, 0, 0, 0);
    chk("combo1_pre.hp", int'(bus.hp), 1);
    tick(0, 0, 1, 1);
    chk_status("combo1", 4, 0, 1, 0, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
